// File: rtl/move_pulse_gen.sv
// Push-button front end for the 2048 game: synchronizes and debounces four
// buttons, then issues one registered single-cycle move pulse per press.
module move_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_u,
    input  logic btn_d,
    input  logic btn_l,
    input  logic btn_r,
    input  logic game_ready,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order is also the priority order: bit 0 (up) wins.
    logic [3:0]       w_btn;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_db;
    logic [CNT_W-1:0] r_cnt [4];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cmd;
    logic [3:0]       w_cmd_nxt;
    logic [3:0]       r_move;
    logic [3:0]       w_move_nxt;
    logic [3:0]       w_prio;
    logic             r_busy;

    assign w_btn = {btn_r, btn_l, btn_d, btn_u};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_db <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_db[i]  <= ~r_db[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Isolate the lowest set bit: the highest-priority pressed button.
    assign w_prio = r_db & (~r_db + 4'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_move_nxt  = '0;
        case (r_state)
            IDLE: begin
                if (|r_db) begin
                    w_cmd_nxt   = w_prio;
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (game_ready) begin
                    w_move_nxt  = r_cmd;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (r_db == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_cmd   <= '0;
            r_move  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            r_move  <= w_move_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign up    = r_move[0];
    assign down  = r_move[1];
    assign left  = r_move[2];
    assign right = r_move[3];
    assign busy  = r_busy;

endmodule
